// File: rtl/prog_clock_divider_if.sv
// Control/observation bundle for prog_clock_divider.
//   Enable    : 1 = count, 0 = freeze divider state
//   Div_in    : requested ratio N
//   Div_load  : 1-cycle strobe capturing Div_in
//   Clock_out : registered divided waveform
//   Tick      : 1-cycle pulse on the cycle Clock_out rises
//   Pending   : a loaded ratio is waiting for the period boundary
//   Count     : current phase counter
interface prog_clock_divider_if #(
  parameter int unsigned W = 8
);

  logic         Enable;
  logic [W-1:0] Div_in;
  logic         Div_load;
  logic         Clock_out;
  logic         Tick;
  logic         Pending;
  logic [W-1:0] Count;

  modport master (
    output Enable, Div_in, Div_load,
    input  Clock_out, Tick, Pending, Count
  );

  modport slave (
    input  Enable, Div_in, Div_load,
    output Clock_out, Tick, Pending, Count
  );

endinterface

// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider (ratio 2..2^W-1).
// Fully synchronous: Clock_out is a registered waveform, never a derived clock.
// Ports:
//   Clock   : system clock
//   Reset   : asynchronous, active-low reset
//   ctrl_io : prog_clock_divider_if.slave (Enable, Div_in, Div_load in;
//             Clock_out, Tick, Pending, Count out)
module prog_clock_divider #(
  parameter int unsigned W           = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  prog_clock_divider_if.slave    ctrl_io
);

  // One extra bit so (R+1)>>1 cannot overflow at R = 2^W-1.
  localparam int unsigned HW = W + 1;

  localparam logic [W-1:0] DefRatio = W'(DEFAULT_DIV);
  localparam logic [W-1:0] DefCount = W'(DEFAULT_DIV - 1);

  logic [W-1:0] ratio_q,      ratio_d;
  logic [W-1:0] count_q,      count_d;
  logic [W-1:0] pend_ratio_q, pend_ratio_d;
  logic         pending_q,    pending_d;
  logic         clk_out_q,    clk_out_d;
  logic         tick_q,       tick_d;

  logic [W-1:0]  load_val;
  logic          wrap;
  logic [HW-1:0] half;

  // Ratios below 2 are meaningless; clamp them to /2.
  assign load_val = (ctrl_io.Div_in < W'(2)) ? W'(2) : ctrl_io.Div_in;

  // Last phase of the current period.
  assign wrap = (count_q == (ratio_q - W'(1)));

  // High-phase length of the period that count_d/ratio_d belong to.
  assign half = (HW'(ratio_d) + HW'(1)) >> 1;

  // Next-state logic.
  always_comb begin
    ratio_d      = ratio_q;
    count_d      = count_q;
    pend_ratio_d = pend_ratio_q;
    pending_d    = pending_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;

    // Loads are captured regardless of Enable; last one wins.
    if (ctrl_io.Div_load) begin
      pend_ratio_d = load_val;
      pending_d    = 1'b1;
    end

    if (ctrl_io.Enable) begin
      if (wrap) begin
        count_d = '0;
        tick_d  = 1'b1;
        // A load coinciding with the wrap bypasses the pending register.
        if (ctrl_io.Div_load) begin
          ratio_d = load_val;
        end else if (pending_q) begin
          ratio_d = pend_ratio_q;
        end
        pending_d = 1'b0;
      end else begin
        count_d = count_q + W'(1);
      end
      clk_out_d = (HW'(count_d) < half);
    end
  end

  // State registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ratio_q      <= DefRatio;
      count_q      <= DefCount;
      pend_ratio_q <= DefRatio;
      pending_q    <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      ratio_q      <= ratio_d;
      count_q      <= count_d;
      pend_ratio_q <= pend_ratio_d;
      pending_q    <= pending_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
    end
  end

  assign ctrl_io.Clock_out = clk_out_q;
  assign ctrl_io.Tick      = tick_q;
  assign ctrl_io.Pending   = pending_q;
  assign ctrl_io.Count     = count_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (W=8, DEFAULT_DIV=2).
module tb_prog_clock_divider;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_errors;

  prog_clock_divider_if #(.W(8)) bus ();

  prog_clock_divider #(.W(8), .DEFAULT_DIV(2)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .ctrl_io (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_load(input logic ld, input logic [7:0] val);
    bus.Div_load = ld;
    bus.Div_in   = val;
  endtask

  // Step until Count reaches target, bounded.
  task automatic wait_count(input logic [7:0] target);
    int n = 0;
    while (bus.Count !== target && n < 600) begin
      step();
      n++;
    end
    n_checks++;
    if (bus.Count !== target) begin
      n_errors++;
      $display("FAIL wait_count: Count=%0d never reached %0d", bus.Count, target);
    end
  endtask

  // Run n cycles expecting ratio r starting just after phase 0.
  task automatic run_ratio(input string name, input int r, input int n);
    logic [9:0] exp_v;
    for (int i = 1; i <= n; i++) begin
      step();
      exp_v = {((i % r) < ((r + 1) / 2)) ? 1'b1 : 1'b0,
               ((i % r) == 0) ? 1'b1 : 1'b0,
               8'(i % r)};
      n_checks++;
      if ({bus.Clock_out, bus.Tick, bus.Count} !== exp_v) begin
        n_errors++;
        $display("FAIL %s cycle %0d: {co,tick,cnt}=%b/%b/%0d expected %b/%b/%0d",
                 name, i, bus.Clock_out, bus.Tick, bus.Count,
                 exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.Enable = 1'b1;
    set_load(1'b0, 8'd0);
    step();
    step();
    n_checks++;
    if ({bus.Clock_out, bus.Tick, bus.Pending, bus.Count} !== {3'b000, 8'd1}) begin
      n_errors++;
      $display("FAIL reset_values: co=%b tick=%b pend=%b cnt=%0d expected 0 0 0 1",
               bus.Clock_out, bus.Tick, bus.Pending, bus.Count);
    end
    Reset = 1'b1;
    step();
    n_checks++;
    if ({bus.Clock_out, bus.Tick, bus.Count} !== {2'b11, 8'd0}) begin
      n_errors++;
      $display("FAIL first_tick: co=%b tick=%b cnt=%0d expected 1 1 0",
               bus.Clock_out, bus.Tick, bus.Count);
    end
    run_ratio("div2_default", 2, 6);
  endtask

  task automatic test_load5();
    wait_count(8'd0);
    set_load(1'b1, 8'd5);
    step();
    set_load(1'b0, 8'd0);
    n_checks++;
    if ({bus.Pending, bus.Clock_out, bus.Count} !== {2'b10, 8'd1}) begin
      n_errors++;
      $display("FAIL load5_pending: pend=%b co=%b cnt=%0d expected 1 0 1",
               bus.Pending, bus.Clock_out, bus.Count);
    end
    step();
    n_checks++;
    if ({bus.Pending, bus.Clock_out, bus.Tick, bus.Count} !== {3'b011, 8'd0}) begin
      n_errors++;
      $display("FAIL load5_apply: pend=%b co=%b tick=%b cnt=%0d expected 0 1 1 0",
               bus.Pending, bus.Clock_out, bus.Tick, bus.Count);
    end
    run_ratio("div5", 5, 10);
  endtask

  task automatic test_load16();
    wait_count(8'd1);
    set_load(1'b1, 8'd16);
    step();
    set_load(1'b0, 8'd0);
    n_checks++;
    if ({bus.Pending, bus.Count} !== {1'b1, 8'd2}) begin
      n_errors++;
      $display("FAIL load16_queued: pend=%b cnt=%0d expected 1 2", bus.Pending, bus.Count);
    end
    step();
    step();
    n_checks++;
    if ({bus.Pending, bus.Tick, bus.Clock_out, bus.Count} !== {3'b100, 8'd4}) begin
      n_errors++;
      $display("FAIL load16_old_period: pend=%b tick=%b co=%b cnt=%0d expected 1 0 0 4",
               bus.Pending, bus.Tick, bus.Clock_out, bus.Count);
    end
    step();
    n_checks++;
    if ({bus.Pending, bus.Tick, bus.Clock_out, bus.Count} !== {3'b011, 8'd0}) begin
      n_errors++;
      $display("FAIL load16_apply: pend=%b tick=%b co=%b cnt=%0d expected 0 1 1 0",
               bus.Pending, bus.Tick, bus.Clock_out, bus.Count);
    end
    run_ratio("div16", 16, 16);
  endtask

  task automatic test_clamp_and_max();
    wait_count(8'd15);
    set_load(1'b1, 8'd0);
    step();
    set_load(1'b0, 8'd0);
    n_checks++;
    if ({bus.Pending, bus.Tick, bus.Clock_out, bus.Count} !== {3'b011, 8'd0}) begin
      n_errors++;
      $display("FAIL div0_bypass: pend=%b tick=%b co=%b cnt=%0d expected 0 1 1 0",
               bus.Pending, bus.Tick, bus.Clock_out, bus.Count);
    end
    run_ratio("div0_as2", 2, 4);
    wait_count(8'd1);
    set_load(1'b1, 8'd1);
    step();
    set_load(1'b0, 8'd0);
    n_checks++;
    if ({bus.Pending, bus.Count} !== {1'b0, 8'd0}) begin
      n_errors++;
      $display("FAIL div1_bypass: pend=%b cnt=%0d expected 0 0", bus.Pending, bus.Count);
    end
    run_ratio("div1_as2", 2, 4);
    wait_count(8'd1);
    set_load(1'b1, 8'd255);
    step();
    set_load(1'b0, 8'd0);
    n_checks++;
    if ({bus.Clock_out, bus.Count} !== {1'b1, 8'd0}) begin
      n_errors++;
      $display("FAIL div255_apply: co=%b cnt=%0d expected 1 0", bus.Clock_out, bus.Count);
    end
    run_ratio("div255", 255, 255);
  endtask

  task automatic test_enable();
    wait_count(8'd254);
    set_load(1'b1, 8'd4);
    step();
    set_load(1'b0, 8'd0);
    step();
    n_checks++;
    if ({bus.Clock_out, bus.Count} !== {1'b1, 8'd1}) begin
      n_errors++;
      $display("FAIL div4_setup: co=%b cnt=%0d expected 1 1", bus.Clock_out, bus.Count);
    end
    bus.Enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) set_load(1'b1, 8'd3);
      else        set_load(1'b0, 8'd0);
      step();
      n_checks++;
      if ({bus.Clock_out, bus.Tick, bus.Count} !== {2'b10, 8'd1}) begin
        n_errors++;
        $display("FAIL frozen cycle %0d: co=%b tick=%b cnt=%0d expected 1 0 1",
                 i, bus.Clock_out, bus.Tick, bus.Count);
      end
    end
    set_load(1'b0, 8'd0);
    n_checks++;
    if (bus.Pending !== 1'b1) begin
      n_errors++;
      $display("FAIL load_while_disabled: pend=%b expected 1", bus.Pending);
    end
    bus.Enable = 1'b1;
    step();
    step();
    n_checks++;
    if ({bus.Clock_out, bus.Pending, bus.Count} !== {2'b01, 8'd3}) begin
      n_errors++;
      $display("FAIL resume_phase: co=%b pend=%b cnt=%0d expected 0 1 3",
               bus.Clock_out, bus.Pending, bus.Count);
    end
    step();
    n_checks++;
    if ({bus.Pending, bus.Tick, bus.Clock_out, bus.Count} !== {3'b011, 8'd0}) begin
      n_errors++;
      $display("FAIL div3_apply: pend=%b tick=%b co=%b cnt=%0d expected 0 1 1 0",
               bus.Pending, bus.Tick, bus.Clock_out, bus.Count);
    end
    run_ratio("div3", 3, 6);
  endtask

  task automatic test_reset_mid();
    wait_count(8'd2);
    set_load(1'b1, 8'd6);
    step();
    set_load(1'b0, 8'd0);
    step();
    step();
    set_load(1'b1, 8'd3);
    step();
    set_load(1'b0, 8'd0);
    n_checks++;
    if ({bus.Pending, bus.Clock_out, bus.Count} !== {2'b10, 8'd3}) begin
      n_errors++;
      $display("FAIL div6_queued: pend=%b co=%b cnt=%0d expected 1 0 3",
               bus.Pending, bus.Clock_out, bus.Count);
    end
    #3;
    Reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.Clock_out, bus.Pending, bus.Tick, bus.Count} !== {3'b000, 8'd1}) begin
      n_errors++;
      $display("FAIL async_reset: co=%b pend=%b tick=%b cnt=%0d expected 0 0 0 1",
               bus.Clock_out, bus.Pending, bus.Tick, bus.Count);
    end
    Reset = 1'b1;
    step();
    n_checks++;
    if ({bus.Clock_out, bus.Tick, bus.Count} !== {2'b11, 8'd0}) begin
      n_errors++;
      $display("FAIL restart_tick: co=%b tick=%b cnt=%0d expected 1 1 0",
               bus.Clock_out, bus.Tick, bus.Count);
    end
    run_ratio("restart_div2", 2, 4);
  endtask

  task automatic test_back_to_back();
    wait_count(8'd1);
    set_load(1'b1, 8'd5);
    step();
    set_load(1'b1, 8'd7);
    step();
    set_load(1'b1, 8'd9);
    step();
    set_load(1'b0, 8'd0);
    n_checks++;
    if ({bus.Pending, bus.Count} !== {1'b1, 8'd2}) begin
      n_errors++;
      $display("FAIL last_wins_queued: pend=%b cnt=%0d expected 1 2", bus.Pending, bus.Count);
    end
    step();
    step();
    step();
    n_checks++;
    if ({bus.Pending, bus.Tick, bus.Count} !== {2'b01, 8'd0}) begin
      n_errors++;
      $display("FAIL last_wins_wrap: pend=%b tick=%b cnt=%0d expected 0 1 0",
               bus.Pending, bus.Tick, bus.Count);
    end
    run_ratio("div9_last_wins", 9, 9);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    Reset      = 1'b0;
    bus.Enable = 1'b0;
    set_load(1'b0, 8'd0);
    test_reset();
    test_load5();
    test_load16();
    test_clamp_and_max();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
